// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared widths, feeder state type and helpers for the PE array
package pe_array_pkg;

  localparam int DATA_W = 18;
  localparam int UP_W   = 24;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } feed_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - enabled shift chain; dout_o is the word entered DEPTH-1 advances earlier
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  logic [DATA_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// rtl/pe_skew_feeder.sv - diagonal-skew left-edge operand feeder with tile flush and done pulse
module pe_skew_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = pe_array_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROWS*DATA_W-1:0] s_data,
  input  logic                   s_last,
  input  logic                   s_mode,
  output logic                   arr_en,
  output logic                   arr_mode,
  output logic [ROWS*DATA_W-1:0] arr_left,
  output logic                   tile_done
);
  import pe_array_pkg::*;

  localparam int CNT_W = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);

  feed_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   first_q;
  logic                   mode_q;
  logic                   en_q;
  logic                   done_q;
  logic                   accept;
  logic                   adv;
  logic [ROWS*DATA_W-1:0] word_d;

  assign s_ready = (state_q == RUN);
  assign accept  = s_valid & s_ready;
  assign adv     = accept | (state_q == FLUSH);
  // Flush pushes zeros so the last real beat walks down to the bottom row.
  assign word_d  = (state_q == RUN) ? s_data : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_line #(
      .DEPTH  (r + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk    (clk),
      .reset  (reset),
      .en_i   (adv),
      .din_i  (word_d[r*DATA_W +: DATA_W]),
      .dout_o (arr_left[r*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      first_q <= 1'b1;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= adv;
      done_q <= (state_q == DONE);
      if (accept && first_q) mode_q <= s_mode;
      case (state_q)
        RUN: begin
          if (accept) begin
            first_q <= 1'b0;
            if (s_last) begin
              if (ROWS > 1) begin
                state_q <= FLUSH;
                cnt_q   <= CNT_W'(ROWS - 1);
              end else begin
                state_q <= DONE;
              end
            end
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          first_q <= 1'b1;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign arr_en    = en_q;
  assign arr_mode  = mode_q;
  assign tile_done = done_q;

endmodule

// File: tb/tb_pe_skew_feeder.sv
// tb/tb_pe_skew_feeder.sv - vector table, directed corner cases and random traffic against a queue model
module tb_pe_skew_feeder;

  localparam int ROWS = 4;
  localparam int DW   = 18;
  localparam int W    = ROWS * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid, s_ready, s_last, s_mode;
  logic [W-1:0]  s_data;
  logic          arr_en, arr_mode, tile_done;
  logic [W-1:0]  arr_left;

  logic          r1_valid, r1_ready, r1_last, r1_mode;
  logic [DW-1:0] r1_data;
  logic          r1_en, r1_amode, r1_done;
  logic [DW-1:0] r1_left;

  always #5 clk = ~clk;

  pe_skew_feeder #(.ROWS(ROWS), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_mode(s_mode), .arr_en(arr_en), .arr_mode(arr_mode),
    .arr_left(arr_left), .tile_done(tile_done)
  );

  pe_skew_feeder #(.ROWS(1), .DATA_W(DW)) dut1 (
    .clk(clk), .reset(reset), .s_valid(r1_valid), .s_ready(r1_ready), .s_data(r1_data),
    .s_last(r1_last), .s_mode(r1_mode), .arr_en(r1_en), .arr_mode(r1_amode),
    .arr_left(r1_left), .tile_done(r1_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: rows see the history of words pushed into the array, row r lagging r pushes.
  int           m_flush;
  bit           m_donest, m_first, m_mode, m_en, m_done;
  logic [W-1:0] hist[$];

  function automatic bit m_ready();
    return (m_flush == 0) && !m_donest;
  endfunction

  task automatic model_reset();
    m_flush = 0; m_donest = 0; m_first = 1; m_mode = 0; m_en = 0; m_done = 0;
    hist.delete();
  endtask

  task automatic push(input logic [W-1:0] w);
    hist.push_back(w);
    if (hist.size() > ROWS) void'(hist.pop_front());
  endtask

  task automatic model_edge();
    bit acc, nxt_done;
    acc      = m_ready() && s_valid;
    nxt_done = 0;
    m_done   = m_donest;
    if (m_donest) m_first = 1;
    if (acc) begin
      push(s_data);
      m_en = 1;
      if (m_first) m_mode = s_mode;
      m_first = 0;
      if (s_last) m_flush = ROWS - 1;
    end else if (m_flush > 0) begin
      push('0);
      m_en = 1;
      m_flush--;
      if (m_flush == 0) nxt_done = 1;
    end else begin
      m_en = 0;
    end
    m_donest = nxt_done;
  endtask

  function automatic logic [W-1:0] exp_left();
    logic [W-1:0] e;
    e = '0;
    for (int r = 0; r < ROWS; r++)
      if (hist.size() > r) e[r*DW +: DW] = hist[hist.size()-1-r][r*DW +: DW];
    return e;
  endfunction

  task automatic check_model();
    chk("model s_ready", W'(s_ready), W'(m_ready()));
    chk("model arr_en", W'(arr_en), W'(m_en));
    chk("model arr_mode", W'(arr_mode), W'(m_mode));
    chk("model tile_done", W'(tile_done), W'(m_done));
    chk("model arr_left", arr_left, exp_left());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit            v;
    bit            last;
    bit            mode;
    logic [DW-1:0] d;
    bit            en;
    logic [DW-1:0] r0;
    logic [DW-1:0] r3;
    bit            done;
    bit            md;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1, 0, 1, 1, 1, 1, 0, 0, 1};
    tbl[1]  = '{1, 1, 0, 2, 1, 2, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 2, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 2, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 2, 0, 1};
    tbl[7]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 9, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 9, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 1, 1, 2, 1, 2, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 5, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 5, 1, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 1, 5, 1, 0, 2, 0, 0};
    tbl[14] = '{1, 0, 1, 5, 0, 0, 2, 1, 0};
    tbl[15] = '{1, 0, 1, 5, 1, 5, 0, 0, 1};
    tbl[16] = '{1, 1, 0, 6, 1, 6, 0, 0, 1};

    reset = 1; s_valid = 0; s_last = 0; s_mode = 0; s_data = '0;
    r1_valid = 0; r1_last = 0; r1_mode = 0; r1_data = '0;
    model_reset();
    @(negedge clk);
    chk("reset arr_en", W'(arr_en), '0);
    chk("reset arr_mode", W'(arr_mode), '0);
    chk("reset arr_left", arr_left, '0);
    chk("reset tile_done", W'(tile_done), '0);
    chk("reset s_ready", W'(s_ready), W'(1));
    reset = 0;

    for (int i = 0; i < 17; i++) begin
      s_valid = tbl[i].v; s_last = tbl[i].last; s_mode = tbl[i].mode;
      s_data  = {ROWS{tbl[i].d}};
      step();
      chk($sformatf("vec%0d arr_en", i), W'(arr_en), W'(tbl[i].en));
      chk($sformatf("vec%0d row0", i), W'(arr_left[0 +: DW]), W'(tbl[i].r0));
      chk($sformatf("vec%0d row3", i), W'(arr_left[3*DW +: DW]), W'(tbl[i].r3));
      chk($sformatf("vec%0d tile_done", i), W'(tile_done), W'(tbl[i].done));
      chk($sformatf("vec%0d arr_mode", i), W'(arr_mode), W'(tbl[i].md));
    end
    s_valid = 0;
    for (int i = 0; i < 6; i++) step();

    // Abort a tile part-way through its flush.
    s_valid = 1; s_last = 1; s_mode = 1; s_data = {ROWS{18'h01234}};
    step();
    s_valid = 0;
    step();
    reset = 1;
    #1;
    chk("async arr_en", W'(arr_en), '0);
    chk("async arr_mode", W'(arr_mode), '0);
    chk("async arr_left", arr_left, '0);
    chk("async tile_done", W'(tile_done), '0);
    model_reset();
    @(negedge clk);
    reset = 0;
    chk("post-reset s_ready", W'(s_ready), W'(1));
    s_valid = 1; s_last = 1; s_mode = 1; s_data = {ROWS{18'h3FFFF}};
    step();
    s_valid = 0;
    for (int i = 0; i < 3; i++) step();
    chk("after-reset row3", W'(arr_left[3*DW +: DW]), W'(18'h3FFFF));
    step();
    chk("after-reset tile_done", W'(tile_done), W'(1));
    step();

    r1_valid = 1; r1_last = 1; r1_data = 18'h0002A;
    step();
    chk("rows1 arr_en", W'(r1_en), W'(1));
    chk("rows1 arr_left", W'(r1_left), W'(18'h0002A));
    chk("rows1 early done", W'(r1_done), '0);
    r1_valid = 0;
    step();
    chk("rows1 tile_done", W'(r1_done), W'(1));
    chk("rows1 en off", W'(r1_en), '0);
    step();
    chk("rows1 done once", W'(r1_done), '0);
    chk("rows1 s_ready", W'(r1_ready), W'(1));

    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_last  = ($urandom_range(0, 3) == 0);
      s_mode  = $urandom_range(0, 1);
      for (int r = 0; r < ROWS; r++) s_data[r*DW +: DW] = DW'($urandom);
      step();
    end
    s_valid = 0;
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
